muldiv_controller: RTL and testbench

MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

---
 rtl/muldiv_pkg.sv | 46 ++++
 rtl/muldiv_controller_iter_counter.sv | 38 +++
 rtl/muldiv_controller.sv | 114 +++++++++++
 tb/tb_muldiv_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the M-extension sequencer
package muldiv_pkg;

    localparam int ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Datapath mode bits derived from one funct3 value.
    typedef struct packed {
        logic div;
        logic signed_a;
        logic signed_b;
        logic sel_hi;
    } op_mode_t;

    function automatic op_mode_t decode_op(input logic [2:0] f3);
        op_mode_t m;
        m = '0;
        case (f3)
            F3_MUL:    m = '{div: 1'b0, signed_a: 1'b0, signed_b: 1'b0, sel_hi: 1'b0};
            F3_MULH:   m = '{div: 1'b0, signed_a: 1'b1, signed_b: 1'b1, sel_hi: 1'b1};
            F3_MULHSU: m = '{div: 1'b0, signed_a: 1'b1, signed_b: 1'b0, sel_hi: 1'b1};
            F3_MULHU:  m = '{div: 1'b0, signed_a: 1'b0, signed_b: 1'b0, sel_hi: 1'b1};
            F3_DIV:    m = '{div: 1'b1, signed_a: 1'b1, signed_b: 1'b1, sel_hi: 1'b0};
            F3_DIVU:   m = '{div: 1'b1, signed_a: 1'b0, signed_b: 1'b0, sel_hi: 1'b0};
            F3_REM:    m = '{div: 1'b1, signed_a: 1'b1, signed_b: 1'b1, sel_hi: 1'b1};
            F3_REMU:   m = '{div: 1'b1, signed_a: 1'b0, signed_b: 1'b0, sel_hi: 1'b1};
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/muldiv_controller_iter_counter.sv
// rtl/muldiv_controller_iter_counter.sv - iteration counter with terminal count
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0 (wins over enable)
//   enable     : count up by one
//   tc         : high while the count equals ITER-1
module iter_counter
    import muldiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    // Width of at least one bit so ITER=1 still elaborates.
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/muldiv_controller.sv
// rtl/muldiv_controller.sv - sequencer for an iterative multiply/divide datapath
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start, funct3 : decode holds a valid M-op and its select
//   flush         : abort any operation, return to IDLE
//   div_zero      : divisor==0 flag, captured together with dp_load
//   stall         : freeze fetch/decode while an operation is in flight
//   dp_load       : load operands into the datapath
//   dp_step       : advance the datapath one iteration
//   dp_div, dp_signed_a, dp_signed_b, dp_sel_hi : datapath mode from latched funct3
//   result_valid  : one-cycle pulse, result ready for write-back
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] funct3,
    input  logic       flush,
    input  logic       div_zero,
    output logic       stall,
    output logic       dp_load,
    output logic       dp_step,
    output logic       dp_div,
    output logic       dp_signed_a,
    output logic       dp_signed_b,
    output logic       dp_sel_hi,
    output logic       result_valid
);

    state_t     state_q, state_d;
    logic [2:0] f3_q;
    logic       dz_q;
    logic       cnt_en;
    logic       cnt_tc;
    op_mode_t   mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            f3_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (dp_load) begin
                f3_q <= funct3;
                dz_q <= div_zero;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        dp_load      = 1'b0;
        dp_step      = 1'b0;
        result_valid = 1'b0;
        cnt_en       = 1'b0;
        // Reset gates the combinational start->load path so every output
        // is quiet while rst_n is low; flush overrides every state.
        if (!rst_n || flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dp_load = 1'b1;
                        stall   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    stall = 1'b1;
                    // Divide by zero needs no iterations: the datapath
                    // result is already defined by the loaded operands.
                    if (f3_q[2] && dz_q) begin
                        state_d = ST_DONE;
                    end else begin
                        dp_step = 1'b1;
                        cnt_en  = 1'b1;
                        if (cnt_tc) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    result_valid = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    iter_counter #(
        .ITER   (ITER)
    ) u_iter_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (dp_load | flush),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    assign mode        = decode_op(f3_q);
    assign dp_div      = mode.div;
    assign dp_signed_a = mode.signed_a;
    assign dp_signed_b = mode.signed_b;
    assign dp_sel_hi   = mode.sel_hi;

endmodule

// File: tb/tb_muldiv_controller.sv
// tb/tb_muldiv_controller.sv - directed self-checking bench for muldiv_controller
module tb_muldiv_controller;

    localparam int ITER = 32;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] funct3;
    logic       flush;
    logic       div_zero;
    logic       stall;
    logic       dp_load;
    logic       dp_step;
    logic       dp_div;
    logic       dp_signed_a;
    logic       dp_signed_b;
    logic       dp_sel_hi;
    logic       result_valid;

    int total;
    int bad;

    muldiv_controller #(
        .ITER         (ITER)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .funct3       (funct3),
        .flush        (flush),
        .div_zero     (div_zero),
        .stall        (stall),
        .dp_load      (dp_load),
        .dp_step      (dp_step),
        .dp_div       (dp_div),
        .dp_signed_a  (dp_signed_a),
        .dp_signed_b  (dp_signed_b),
        .dp_sel_hi    (dp_sel_hi),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall, dp_load, dp_step, result_valid}
    wire [3:0] ctl  = {stall, dp_load, dp_step, result_valid};
    // {dp_div, dp_signed_a, dp_signed_b, dp_sel_hi}
    wire [3:0] mode = {dp_div, dp_signed_a, dp_signed_b, dp_sel_hi};

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        #3;
        chk(tag, ctl, 4'b0000);
        next_cycle();
    endtask

    // One operation started in cycle 0; result_valid expected in cycle 'last'.
    // After cycle 0 funct3/div_zero are driven with the opposite values so
    // the mode outputs prove they come from the latched copy.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic dz,
                          input logic [3:0] exp_mode, input int last);
        logic [3:0] exp_ctl;
        for (int c = 0; c <= last; c++) begin
            start    = (c == 0);
            funct3   = (c == 0) ? f3 : ~f3;
            div_zero = (c == 0) ? dz : ~dz;
            #3;
            exp_ctl = {c < last, c == 0, (c >= 1 && c < last && !(f3[2] && dz)), c == last};
            chk($sformatf("%s_ctl_c%0d", tag, c), ctl, exp_ctl);
            if (c >= 1) chk($sformatf("%s_mode_c%0d", tag, c), mode, exp_mode);
            next_cycle();
        end
        start = 1'b0;
        idle_check({tag, "_idle"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        funct3   = 3'b100;
        flush    = 1'b0;
        div_zero = 1'b0;

        // Reset: outputs quiet even with start held high.
        #2;
        chk("reset_ctl", ctl, 4'b0000);
        chk("reset_mode", mode, 4'b0000);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        next_cycle();
        idle_check("post_reset_idle");

        // MUL, full length: load c0, step c1..32, valid c33, stall 33 cycles.
        run_op("mul", 3'b000, 1'b0, 4'b0000, ITER + 1);
        // DIV by zero: no steps, valid in cycle 2.
        run_op("div_dz", 3'b100, 1'b1, 4'b1110, 2);
        // MULHSU: signed_a only, high word.
        run_op("mulhsu", 3'b010, 1'b0, 4'b0101, ITER + 1);
        // div_zero must not shorten a multiply.
        run_op("mulh_dz", 3'b001, 1'b1, 4'b0111, ITER + 1);
        // REM by zero.
        run_op("rem_dz", 3'b110, 1'b1, 4'b1111, 2);
        // DIVU, non-zero divisor.
        run_op("divu", 3'b101, 1'b0, 4'b1000, ITER + 1);

        // Flush in cycle 10 of a MUL, restart in cycle 12 -> valid in 45.
        for (int c = 0; c <= 11; c++) begin
            start  = (c == 0);
            funct3 = 3'b000;
            flush  = (c == 10);
            #3;
            e = (c >= 10) ? 4'b0000 : {1'b1, c == 0, c >= 1, 1'b0};
            chk($sformatf("flush_ctl_c%0d", c), ctl, e);
            next_cycle();
        end
        flush = 1'b0;
        run_op("flush_restart", 3'b000, 1'b0, 4'b0000, ITER + 1);

        // Start and flush together in IDLE: nothing loads.
        start = 1'b1;
        flush = 1'b1;
        #3;
        chk("start_flush_ctl", ctl, 4'b0000);
        next_cycle();
        start = 1'b0;
        flush = 1'b0;
        idle_check("start_flush_next");

        // Asynchronous reset in cycle 5 of a DIV.
        for (int c = 0; c <= 4; c++) begin
            start    = (c == 0);
            funct3   = 3'b100;
            div_zero = 1'b0;
            next_cycle();
        end
        #3;
        chk("rst_pre_ctl", ctl, 4'b1010);
        chk("rst_pre_mode", mode, 4'b1110);
        start = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", ctl, 4'b0000);
        chk("rst_mid_mode", mode, 4'b0000);
        @(posedge clk);
        #3;
        chk("rst_hold_ctl", ctl, 4'b0000);
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #3;
            chk($sformatf("rst_after_c%0d", c), ctl, 4'b0000);
        end
        next_cycle();

        // REMU with start held through DONE: second load in cycle 34.
        for (int c = 0; c <= 2 * ITER + 3; c++) begin
            start    = (c <= ITER + 2);
            funct3   = 3'b111;
            div_zero = 1'b0;
            #3;
            e[3] = (c <= ITER) || (c >= ITER + 2 && c <= 2 * ITER + 2);
            e[2] = (c == 0) || (c == ITER + 2);
            e[1] = (c >= 1 && c <= ITER) || (c >= ITER + 3 && c <= 2 * ITER + 2);
            e[0] = (c == ITER + 1) || (c == 2 * ITER + 3);
            chk($sformatf("b2b_ctl_c%0d", c), ctl, e);
            if (c >= 1) chk($sformatf("b2b_mode_c%0d", c), mode, 4'b1001);
            next_cycle();
        end
        start = 1'b0;
        idle_check("b2b_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
